// File: rtl/comp_seq_ctrl.sv
// Sequential magnitude comparator: walks two unsigned operands two bits per cycle,
// MSB slice first, stopping at the first differing slice.
module comp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NS    = WIDTH / 2;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic [1:0]         sa, sb;

  // Mux-based slice select keeps the index arithmetic width-clean.
  function automatic logic [1:0] slice_of(input logic [WIDTH-1:0] v,
                                          input logic [IDX_W-1:0] k);
    logic [1:0] s;
    s = 2'b00;
    for (int i = 0; i < NS; i++) begin
      if (k == IDX_W'(i)) s = v[2*i +: 2];
    end
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    sa      = slice_of(ra_q, idx_q);
    sb      = slice_of(rb_q, idx_q);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = A;
          rb_d    = B;
          idx_d   = IDX_W'(NS - 1);
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (sa != sb) begin
          gt_d    = (sa > sb);
          lt_d    = !(sa > sb);
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from registers so no input reaches them combinationally.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    eq   = eq_q;
    gt   = gt_q;
    lt   = lt_q;
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed and randomised bench for comp_seq_ctrl at WIDTH=8 and WIDTH=2.
module tb_comp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0;
  logic [1:0] A2 = '0, B2 = '0;
  logic       busy8, done8, eq8, gt8, lt8;
  logic       busy2, done2, eq2, gt2, lt2;
  int         nchk = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  comp_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
  );

  comp_seq_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2),
    .busy(busy2), .done(done2), .eq(eq2), .gt(gt2), .lt(lt2)
  );

  // Position (1-based from MSB) of first differing slice; NS when equal.
  function automatic int m_of8(input logic [7:0] a, input logic [7:0] b);
    for (int k = 3; k >= 0; k--) begin
      if (a[2*k +: 2] != b[2*k +: 2]) return 4 - k;
    end
    return 4;
  endfunction

  // Called in IDLE at posedge+1; returns once the block is back in IDLE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int bcnt, output logic [2:0] f, output int bad);
    A8 = a; B8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; bcnt = 0; bad = 0;
    if (busy8) bcnt++;
    if (busy8 && {eq8, gt8, lt8} != 3'b000) bad++;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
      if (busy8 && {eq8, gt8, lt8} != 3'b000) bad++;
    end
    f = {eq8, gt8, lt8};
    @(posedge clk); #1;
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b,
                      output int lat, output logic [2:0] f);
    A2 = a; B2 = b; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    f = {eq2, gt2, lt2};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
      nerr++; $display("FAIL reset_w8 got %b expected 00000", {busy8, done8, eq8, gt8, lt8});
    end
    nchk++;
    if ({busy2, done2, eq2, gt2, lt2} !== 5'b0) begin
      nerr++; $display("FAIL reset_w2 got %b expected 00000", {busy2, done2, eq2, gt2, lt2});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_equal;
    int lat, bcnt, bad;
    logic [2:0] f;
    run8(8'hA5, 8'hA5, lat, bcnt, f, bad);
    nchk++;
    if (lat !== 4) begin nerr++; $display("FAIL eq_latency got %0d expected 4", lat); end
    nchk++;
    if (bcnt !== 4) begin nerr++; $display("FAIL eq_busy_cycles got %0d expected 4", bcnt); end
    nchk++;
    if (f !== 3'b100) begin nerr++; $display("FAIL eq_flags got %b expected 100", f); end
    nchk++;
    if (bad !== 0) begin nerr++; $display("FAIL eq_flags_while_busy got %0d expected 0", bad); end
    A8 = 8'h00; B8 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({busy8, done8, eq8, gt8, lt8} !== 5'b00100) begin
      nerr++; $display("FAIL eq_hold got %b expected 00100", {busy8, done8, eq8, gt8, lt8});
    end
  endtask

  task automatic test_slices;
    int lat, bcnt, bad;
    logic [2:0] f;
    run8(8'hC0, 8'h80, lat, bcnt, f, bad);
    nchk++;
    if ({lat, f} !== {32'd1, 3'b010}) begin
      nerr++; $display("FAIL c0_80 got lat=%0d flags=%b expected lat=1 flags=010", lat, f);
    end
    run8(8'h12, 8'h13, lat, bcnt, f, bad);
    nchk++;
    if ({lat, f} !== {32'd4, 3'b001}) begin
      nerr++; $display("FAIL 12_13 got lat=%0d flags=%b expected lat=4 flags=001", lat, f);
    end
    run8(8'h00, 8'hFF, lat, bcnt, f, bad);
    nchk++;
    if ({lat, f} !== {32'd1, 3'b001}) begin
      nerr++; $display("FAIL 00_ff got lat=%0d flags=%b expected lat=1 flags=001", lat, f);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_t [10];
    exp_t = '{5'b10000, 5'b01010, 5'b00010, 5'b10000, 5'b01001,
              5'b00001, 5'b10000, 5'b01010, 5'b00010, 5'b00010};
    A8 = 8'hC0; B8 = 8'h80; start8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      nchk++;
      if ({busy8, done8, eq8, gt8, lt8} !== exp_t[i]) begin
        nerr++;
        $display("FAIL b2b_step%0d got %b expected %b", i, {busy8, done8, eq8, gt8, lt8}, exp_t[i]);
      end
      if (i == 0) begin A8 = 8'h00; B8 = 8'hFF; end
      if (i == 3) begin A8 = 8'hF0; B8 = 8'h0F; end
      if (i == 7) start8 = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, bad, pulses;
    logic [2:0] f;
    A8 = 8'hA5; B8 = 8'hA5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nchk++;
    if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
      nerr++; $display("FAIL rst_mid got %b expected 00000", {busy8, done8, eq8, gt8, lt8});
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    nchk++;
    if (pulses !== 0) begin nerr++; $display("FAIL rst_mid_no_done got %0d active cycles expected 0", pulses); end
    run8(8'hC0, 8'h80, lat, bcnt, f, bad);
    nchk++;
    if ({lat, f} !== {32'd1, 3'b010}) begin
      nerr++; $display("FAIL rst_mid_rerun got lat=%0d flags=%b expected lat=1 flags=010", lat, f);
    end
  endtask

  task automatic test_rst_start;
    rst = 1'b1; start8 = 1'b1; A8 = 8'hC0; B8 = 8'h80;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    nchk++;
    if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
      nerr++; $display("FAIL rst_start got %b expected 00000", {busy8, done8, eq8, gt8, lt8});
    end
    @(posedge clk); #1;
    nchk++;
    if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
      nerr++; $display("FAIL rst_start_idle got %b expected 00000", {busy8, done8, eq8, gt8, lt8});
    end
  endtask

  task automatic test_random8;
    int lat, bcnt, bad, m;
    logic [2:0] f, ef;
    logic [7:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a ^ 8'($urandom_range(0, 3)) : 8'($urandom);
      m = m_of8(a, b);
      ef = {a == b, a > b, a < b};
      run8(a, b, lat, bcnt, f, bad);
      nchk++;
      if (f !== ef) begin nerr++; $display("FAIL rand8_flags a=%h b=%h got %b expected %b", a, b, f, ef); end
      nchk++;
      if (lat !== m || bcnt !== m || bad !== 0) begin
        nerr++; $display("FAIL rand8_latency a=%h b=%h got lat=%0d busy=%0d bad=%0d expected %0d", a, b, lat, bcnt, bad, m);
      end
    end
  endtask

  task automatic test_random2;
    int lat;
    logic [2:0] f, ef;
    logic [1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 2'($urandom);
      b = 2'($urandom);
      ef = {a == b, a > b, a < b};
      run2(a, b, lat, f);
      nchk++;
      if (f !== ef || lat !== 1) begin
        nerr++; $display("FAIL rand2 a=%0d b=%0d got flags=%b lat=%0d expected flags=%b lat=1", a, b, f, lat, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_slices();
    test_back_to_back();
    test_reset_mid();
    test_rst_start();
    test_random8();
    test_random2();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/comp_seq_ctrl.md
# comp_seq_ctrl

Sequential controller that compares two WIDTH-bit unsigned operands two bits per cycle, MSB slice first. Each cycle uses one 2-bit equality/magnitude slice, the same function as the workshop's combinational 2-bit comparator. The block sits between a requester (testbench, UART command decoder or switch/button front-end) and the comparator datapath. It owns operand capture, slice sequencing, early termination and a start/done handshake.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2; number of slices NS = WIDTH/2
- clk  in  1  system clock, rising-edge active
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A, unsigned; sampled on accepted start
- B  in  WIDTH  operand B, unsigned; sampled on accepted start
- busy  out  1  high while a comparison is in progress (state RUN)
- done  out  1  one-cycle pulse, results valid (state DONE)
- eq  out  1  A == B
- gt  out  1  A > B
- lt  out  1  A < B

## Operation
- Registers:
  - ra, rb: WIDTH-bit captured operands
  - idx: slice index, ceil(log2(NS)) bits, minimum 1 bit
  - state
  - eq, gt, lt result flags
- Slice k is bits [2k+1:2k]. Slice compare within a cycle:
  - equal if ra slice == rb slice
  - greater if ra slice > rb slice as 2-bit unsigned
- FSM states:
  - IDLE: busy=0, done=0. If start=1, latch A→ra and B→rb, set idx=NS-1, clear eq/gt/lt to 0, go to RUN. If start=0, hold the flags.
  - RUN: busy=1. Compare slice idx.
    - Differ: set gt (ra slice greater) or lt (otherwise), go to DONE.
    - Equal and idx==0: set eq, go to DONE.
    - Equal and idx>0: idx←idx-1, stay in RUN.
  - DONE: done=1, busy=0. Unconditionally go to IDLE next cycle.
- start is ignored in RUN and DONE. It is not queued.
- A and B may change freely after the accepting edge; only ra and rb are used.
- Exactly one of eq/gt/lt is 1 from DONE until the next accepted start. All three are 0 while busy.
- Reset (rst=1 at any edge, including mid-RUN or in DONE):
  - state=IDLE; busy=done=eq=gt=lt=0; ra=rb=0; idx=0
  - rst has priority over start on the same edge
  - an interrupted comparison produces no done pulse

## Timing
- Reset values of all outputs: 0.
- Accepting edge is E0 (start=1 in IDLE).
- Let m be the position, counted from the MSB and 1-based, of the first differing slice; m=NS if the operands are equal.
  - Result flags are registered at edge Em.
  - done=1 for the single cycle between Em and Em+1.
  - busy=1 from E0 to Em.
- Latency from accepting edge to done:
  - minimum 1 cycle (MSB slice differs)
  - maximum NS cycles (equal operands, or the difference is only in slice 0)
- Throughput: the next start can be accepted at Em+1, when the block is back in IDLE. Minimum spacing between accepted starts is m+1 cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational path from A, B or start to any output.

## Test plan
- Reset, then WIDTH=8, A=8'hA5, B=8'hA5, start one cycle → busy for 4 cycles, done at cycle 4 after E0, eq=1, gt=lt=0, flags held until next start.
- A=8'hC0, B=8'h80 → done 1 cycle after E0, gt=1. A=8'h12, B=8'h13 → done at cycle 4, lt=1. A=8'h00, B=8'hFF → done at cycle 1, lt=1.
- Start held high continuously with alternating operand pairs → each comparison is accepted only in IDLE (spacing m+1). Pulses during RUN/DONE are ignored, and ra/rb are unaffected by A/B changes after E0.
- rst asserted at cycle 2 of a 4-cycle equal-operand compare → next cycle all outputs 0, state IDLE, no done pulse. A following start runs normally.
- rst and start high on the same edge → remains IDLE with outputs 0.
- Randomised check over 1000 pairs at WIDTH=8 and WIDTH=2 → each flag matches A==B, A>B or A<B, and latency equals m as defined above.
